// File: rtl/branch_resolve_unit.sv
// Resolves RV32I conditional branches (decode, compare, target) and trains a direct-mapped 2-bit BHT.
// Latency: one cycle from sampled inputs to registered result; BHT lookup is combinational.
// No backpressure: accepts one branch every cycle, never stalls.
module branch_resolve_unit #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 16,
    parameter logic [1:0] BHT_INIT  = 2'b01,
    parameter int         CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [31:0]      insn,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    output logic             resolved_valid,
    output logic             pc_alu_sel,
    output logic [XLEN-1:0]  target,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX = $clog2(BHT_DEPTH);

    logic [1:0]      bht [BHT_DEPTH];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            legal;
    logic            taken;
    logic            rs_eq;
    logic            rs_lt;
    logic            rs_ltu;
    logic [12:0]     imm13;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt_next;
    logic            mis_next;
    logic            do_update;
    logic [IDX-1:0]  upd_idx;
    logic [IDX-1:0]  lk_idx;
    logic [1:0]      ctr_cur;
    logic            unused_bits;

    assign opcode  = insn[6:0];
    assign funct3  = insn[14:12];
    assign legal   = (opcode == 7'b1100011) && (funct3 != 3'b010) && (funct3 != 3'b011);

    assign rs_eq   = (rs1_val == rs2_val);
    assign rs_lt   = ($signed(rs1_val) < $signed(rs2_val));
    assign rs_ltu  = (rs1_val < rs2_val);

    // B-type immediate; bit 0 is always zero so the offset stays halfword aligned
    assign imm13    = {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm      = {{(XLEN-12){imm13[12]}}, imm13[11:0]};
    assign tgt_next = pc + imm;

    assign mis_next  = taken != pred_taken_i;
    assign do_update = valid_i && legal;

    assign upd_idx = pc[IDX+1:2];
    assign lk_idx  = lookup_pc[IDX+1:2];
    assign ctr_cur = bht[upd_idx];

    // No bypass: fetch sees the stored counter, so a same-cycle update shows up one cycle later
    assign lookup_taken = bht[lk_idx][1];

    // Operand fields and PC bits outside the index slice are intentionally ignored here
    assign unused_bits = ^{insn, lookup_pc};

    // Branch condition selected by funct3; illegal funct3 values never count as taken
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = rs_eq;
            3'b001:  taken = !rs_eq;
            3'b100:  taken = rs_lt;
            3'b101:  taken = !rs_lt;
            3'b110:  taken = rs_ltu;
            3'b111:  taken = !rs_ltu;
            default: taken = 1'b0;
        endcase
    end

    // BHT training: saturating 2-bit counter per entry, only on legal valid branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (do_update) begin
            if (taken) begin
                if (ctr_cur != 2'b11) begin
                    bht[upd_idx] <= ctr_cur + 2'd1;
                end
            end else begin
                if (ctr_cur != 2'b00) begin
                    bht[upd_idx] <= ctr_cur - 2'd1;
                end
            end
        end
    end

    // Statistics counters stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (do_update) begin
            if (branch_cnt != {CNT_W{1'b1}}) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mis_next && (mispred_cnt != {CNT_W{1'b1}})) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

    // Registered resolution result; target holds across idle cycles, clears on illegal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved_valid <= 1'b0;
            pc_alu_sel     <= 1'b0;
            mispredict     <= 1'b0;
            illegal        <= 1'b0;
            target         <= '0;
        end else if (!valid_i) begin
            resolved_valid <= 1'b0;
            pc_alu_sel     <= 1'b0;
            mispredict     <= 1'b0;
            illegal        <= 1'b0;
        end else if (!legal) begin
            resolved_valid <= 1'b1;
            pc_alu_sel     <= 1'b0;
            mispredict     <= 1'b0;
            illegal        <= 1'b1;
            target         <= '0;
        end else begin
            resolved_valid <= 1'b1;
            pc_alu_sel     <= taken;
            mispredict     <= mis_next;
            illegal        <= 1'b0;
            target         <= tgt_next;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        pred_taken_i;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic        resolved_valid;
    logic        pc_alu_sel;
    logic [31:0] target;
    logic        mispredict;
    logic        illegal;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_resolve_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .insn           (insn),
        .pc             (pc),
        .rs1_val        (rs1_val),
        .rs2_val        (rs2_val),
        .pred_taken_i   (pred_taken_i),
        .lookup_pc      (lookup_pc),
        .lookup_taken   (lookup_taken),
        .resolved_valid (resolved_valid),
        .pc_alu_sel     (pc_alu_sel),
        .target         (target),
        .mispredict     (mispredict),
        .illegal        (illegal),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        sel;
        logic        mis;
        logic        ill;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    int          m_bht[16];
    logic [31:0] m_tgt;
    longint      m_bc;
    longint      m_mc;
    localparam longint CMAX = 64'd4294967295;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_tgt = 0;
        m_bc  = 0;
        m_mc  = 0;
    endtask

    function automatic int bidx(input logic [31:0] a);
        return int'((a >> 2) & 32'd15);
    endfunction

    // Called at posedge+1; returns at the next posedge+1 with the expectation queued
    task automatic issue(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input logic pr,
                         input logic [31:0] lpc);
        exp_t        e;
        logic [2:0]  f3;
        logic        lgl;
        logic        tk;
        int unsigned raw;
        int          off;
        int          k;
        valid_i      = v;
        insn         = ins;
        pc           = p;
        rs1_val      = a;
        rs2_val      = b;
        pred_taken_i = pr;
        lookup_pc    = lpc;
        #2;
        chk("lookup_taken", {63'd0, lookup_taken}, {63'd0, (m_bht[bidx(lpc)] >= 2)});

        f3  = ins[14:12];
        lgl = (ins[6:0] == 7'h63) && (f3 != 3'd2) && (f3 != 3'd3);
        case (f3)
            3'd0:    tk = (a == b);
            3'd1:    tk = (a != b);
            3'd4:    tk = ($signed(a) < $signed(b));
            3'd5:    tk = ($signed(a) >= $signed(b));
            3'd6:    tk = (a < b);
            3'd7:    tk = (a >= b);
            default: tk = 1'b0;
        endcase
        raw = {19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        off = (raw >= 4096) ? int'(raw) - 8192 : int'(raw);

        @(posedge clk);
        if (!v) begin
            e.rv = 0; e.sel = 0; e.mis = 0; e.ill = 0;
        end else if (!lgl) begin
            e.rv = 1; e.sel = 0; e.mis = 0; e.ill = 1;
            m_tgt = 0;
        end else begin
            e.rv = 1; e.sel = tk; e.mis = (tk != pr); e.ill = 0;
            m_tgt = p + 32'(off);
            k = bidx(p);
            m_bht[k] = tk ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3)
                          : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
            if (m_bc < CMAX) m_bc++;
            if (e.mis && m_mc < CMAX) m_mc++;
        end
        e.tgt = m_tgt;
        e.bc  = 32'(m_bc);
        e.mc  = 32'(m_mc);
        q.push_back(e);
        #1;
    endtask

    // Monitor: every negedge out of reset, pop one expectation and compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("resolved_valid", {63'd0, resolved_valid}, {63'd0, e.rv});
                    chk("pc_alu_sel",     {63'd0, pc_alu_sel},     {63'd0, e.sel});
                    chk("mispredict",     {63'd0, mispredict},     {63'd0, e.mis});
                    chk("illegal",        {63'd0, illegal},        {63'd0, e.ill});
                    chk("target",         {32'd0, target},         {32'd0, e.tgt});
                    chk("branch_cnt",     {32'd0, branch_cnt},     {32'd0, e.bc});
                    chk("mispred_cnt",    {32'd0, mispred_cnt},    {32'd0, e.mc});
                end else begin
                    chk("idle_resolved_valid", {63'd0, resolved_valid}, 64'd0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_resolved_valid"}, {63'd0, resolved_valid}, 64'd0);
        chk({tag, "_pc_alu_sel"},     {63'd0, pc_alu_sel},     64'd0);
        chk({tag, "_mispredict"},     {63'd0, mispredict},     64'd0);
        chk({tag, "_illegal"},        {63'd0, illegal},        64'd0);
        chk({tag, "_target"},         {32'd0, target},         64'd0);
        chk({tag, "_branch_cnt"},     {32'd0, branch_cnt},     64'd0);
        chk({tag, "_mispred_cnt"},    {32'd0, mispred_cnt},    64'd0);
    endtask

    logic [31:0] r_insn;
    logic [31:0] r_pc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_v;
    int          wait_cnt;

    initial begin
        rst_n        = 1'b0;
        valid_i      = 1'b0;
        insn         = '0;
        pc           = '0;
        rs1_val      = '0;
        rs2_val      = '0;
        pred_taken_i = 1'b0;
        lookup_pc    = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        chk("reset_lookup", {63'd0, lookup_taken}, 64'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // BEQ taken then not taken
        issue(1, 32'h00520463, 32'h100, 32'd5, 32'd5, 0, 32'h100);
        issue(1, 32'h00520463, 32'h100, 32'd5, 32'd6, 0, 32'h100);
        // Signed vs unsigned
        issue(1, 32'h00524463, 32'h200, 32'hFFFFFFFF, 32'd1, 1, 32'h200);
        issue(1, 32'h00526463, 32'h200, 32'hFFFFFFFF, 32'd1, 1, 32'h200);
        // Negative offset wraps below zero
        issue(1, 32'hFE209EE3, 32'h0, 32'd1, 32'd2, 0, 32'h0);
        // Illegal encoding, then idle cycle (target must hold at 0)
        issue(1, 32'h00522463, 32'h100, 32'd5, 32'd5, 1, 32'h100);
        issue(0, 32'h00520463, 32'h104, 32'd0, 32'd0, 0, 32'h100);
        // BHT training at 0x100: lookups at 0x100 and alias 0x140
        issue(1, 32'h00520463, 32'h100, 32'd7, 32'd7, 1, 32'h100);
        issue(1, 32'h00520463, 32'h100, 32'd7, 32'd7, 1, 32'h100);
        issue(1, 32'h00520463, 32'h100, 32'd7, 32'd7, 1, 32'h140);
        issue(1, 32'h00521463, 32'h100, 32'd7, 32'd7, 0, 32'h140);
        issue(1, 32'h00520463, 32'h100, 32'd7, 32'd7, 0, 32'h100);
        issue(0, 32'h0, 32'h0, 32'd0, 32'd0, 0, 32'h140);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r_v    = ($urandom_range(0, 9) < 8);
            r_insn = $urandom();
            if ($urandom_range(0, 9) < 9) r_insn[6:0] = 7'h63;
            r_pc   = $urandom_range(0, 3) == 0 ? $urandom() : {$urandom_range(0, 255), 2'b00};
            r_a    = $urandom();
            case ($urandom_range(0, 3))
                0:       r_b = r_a;
                1:       r_b = 32'hFFFFFFFF - r_a;
                default: r_b = $urandom();
            endcase
            issue(r_v, r_insn, r_pc, r_a, r_b, 1'($urandom_range(0, 1)),
                  {$urandom_range(0, 255), 2'b00});
        end

        // Train idx 0 up, leave a taken result on the outputs, then reset between edges
        issue(1, 32'h00520463, 32'h100, 32'd1, 32'd1, 1, 32'h100);
        issue(1, 32'h00520463, 32'h100, 32'd1, 32'd1, 1, 32'h100);
        issue(1, 32'h00520463, 32'h100, 32'd1, 32'd1, 0, 32'h100);
        q.delete();
        chk("pre_reset_sel", {63'd0, pc_alu_sel}, 64'd1);
        valid_i = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("midreset");
        for (int i = 0; i < 16; i++) begin
            lookup_pc = 32'(i * 4);
            #1;
            chk("midreset_lookup", {63'd0, lookup_taken}, 64'd0);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1, 32'h00520463, 32'h100, 32'd3, 32'd3, 1, 32'h100);
        issue(0, 32'h0, 32'h0, 32'd0, 32'd0, 0, 32'h100);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution unit for the RV32I execute stage. It decodes all six B-type conditional branches and performs the rs1/rs2 comparison internally. It produces a registered taken/target result with `pc_alu_sel` for PC selection and checks the result against the fetch-stage prediction. A direct-mapped 2-bit saturating-counter branch history table (BHT) is updated from resolved outcomes and exposes a combinational lookup port to fetch, along with saturating statistics counters.

## Interface
Parameters:
- `XLEN`, 32: datapath width of PC and operands; min 13.
- `BHT_DEPTH`, 16: BHT entries; power of two, ≥ 2.
- `BHT_INIT`, 2'b01: counter value after reset (weakly not-taken).
- `CNT_W`, 32: width of statistics counters.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  branch instruction present this cycle.
- `insn`  in  32  instruction word.
- `pc`  in  XLEN  address of `insn`.
- `rs1_val`, `rs2_val`  in  XLEN  operand values.
- `pred_taken_i`  in  1  prediction fetch used for this instruction.
- `lookup_pc`  in  XLEN  fetch PC for BHT read.
- `lookup_taken`  out  1  combinational: MSB of BHT entry indexed by `lookup_pc`.
- `resolved_valid`  out  1  registered: result below is valid.
- `pc_alu_sel`  out  1  registered: 1 selects branch target, 0 selects PC+4.
- `target`  out  XLEN  registered branch target.
- `mispredict`  out  1  registered: taken ≠ `pred_taken_i`.
- `illegal`  out  1  registered: `valid_i` with non-branch encoding.
- `branch_cnt`, `mispred_cnt`  out  CNT_W  saturating counters.

## Operation
- Legal branch: `insn[6:0]` is 7'b1100011 and funct3 is in {000,001,100,101,110,111}.
- Branch conditions by funct3:
  - 000 BEQ: rs1 == rs2.
  - 001 BNE: rs1 != rs2.
  - 100 BLT: signed rs1 < rs2.
  - 101 BGE: signed rs1 >= rs2.
  - 110 BLTU: unsigned rs1 < rs2.
  - 111 BGEU: unsigned rs1 >= rs2.
- Immediate: {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}, sign-extended to XLEN.
- Target: `pc` + imm, modulo 2^XLEN (wraps, no overflow flag).
- BHT index: `pc[IDX+1:2]`, where IDX = log2(BHT_DEPTH). Same slice of `lookup_pc` for the lookup port.
- On a legal valid branch:
  - counter increments if taken, saturating at 3.
  - counter decrements if not taken, saturating at 0.
  - `branch_cnt` increments, saturating at 2^CNT_W−1.
  - `mispred_cnt` increments on mispredict, also saturating.
- Illegal valid encoding:
  - `illegal`=1, `pc_alu_sel`=0, `mispredict`=0, `target`=0.
  - no BHT or counter update.
- `valid_i`=0: `resolved_valid`, `pc_alu_sel`, `mispredict`, `illegal` are 0 next cycle; `target` holds its previous value.
- The lookup port has no bypass. If lookup and update hit the same index in one cycle, `lookup_taken` shows the pre-update value; the new value is visible next cycle.

## Timing
- Latency 1 cycle: inputs sampled at edge N produce outputs valid after edge N, for the whole of cycle N+1.
- Throughput is one branch per cycle; no stall or backpressure.
- Back-to-back branches to the same index see cumulative counter updates: the second update applies to the already-updated value.
- Reset (`rst_n`=0), at any time including mid-stream, takes effect immediately without waiting for `clk`:
  - `resolved_valid`, `pc_alu_sel`, `mispredict`, `illegal` = 0.
  - `target` = 0.
  - `branch_cnt`, `mispred_cnt` = 0.
  - every BHT entry = `BHT_INIT`.
- An instruction in flight when reset asserts is discarded.
- Release of `rst_n` is synchronised externally; the first sampling edge is the first rising `clk` with `rst_n`=1.
- `lookup_taken` is purely combinational from `lookup_pc` and BHT state.

## Test plan
- BEQ taken: `insn`=32'h00520463, `pc`=0x100, rs1=rs2=5, `pred_taken_i`=0 → next cycle `pc_alu_sel`=1, `target`=0x108, `mispredict`=1, `branch_cnt`=1, `mispred_cnt`=1. Same insn with rs1=5, rs2=6 → `pc_alu_sel`=0, `mispredict`=0.
- Signed vs unsigned compare, rs1=0xFFFFFFFF, rs2=1: BLT 32'h00524463 → taken; BLTU 32'h00526463 → not taken.
- Negative offset wrap: BNE 32'h FE209EE3 (−4), `pc`=0x0, rs1=1, rs2=2 → taken, `target`=0xFFFFFFFC.
- BHT training: two taken branches at `pc`=0x100 on consecutive cycles.
  - `lookup_pc`=0x100 reads 0 during the first update cycle and 1 after it.
  - counter reaches 3; a third taken branch keeps it at 3.
  - `lookup_pc`=0x140 (aliases with BHT_DEPTH=16) also reads 1.
- Illegal encoding: `valid_i`=1, `insn`=32'h00522463 (funct3 010) → `illegal`=1, `pc_alu_sel`=0, counters and BHT unchanged.
- Reset mid-stream: drive `rst_n`=0 between clock edges while `pc_alu_sel`=1 → outputs 0 at once, counters 0, all lookups return `BHT_INIT`[1].
